// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the write-back stage, the register file and
// the forwarding unit.
//   XLEN      : datapath width
//   NREG      : number of architectural registers (register 0 reads as zero)
//   ADDR_W    : register address width, 2**ADDR_W == NREG
//   CNT_W     : default width of the write-back commit counter
//   ZERO_REG  : index of the hardwired-zero register
//   wb_sel_e  : MemToReg select encoding (SEL_ALU=0, SEL_MEM=1)
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Write-back value select: picks load data or the ALU result. Shared with
// the forwarding unit so both see the same selected value.
//   i_sel  : MemToReg select (SEL_MEM -> i_mem, SEL_ALU -> i_alu)
//   i_alu  : ALU result
//   i_mem  : load data
//   o_data : selected write-back value (combinational)
module wb_mux
  import cpu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_alu,
  input  logic [W-1:0] i_mem,
  output logic [W-1:0] o_data
);

  always_comb begin
    o_data = (wb_sel_e'(i_sel) == SEL_MEM) ? i_mem : i_alu;
  end

endmodule

// File: rtl/wb_register_file.sv
// Write-back end of MEM/WB plus the general register file.
// Selects the write-back value, commits it to one of NREG registers, serves
// two combinational read ports with write-through bypass, and counts commits.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   RegWrite_i, MemToReg_i   : write enable and write-back source select
//   RDData_i, ALUResult_i    : write-back candidates
//   WriteReg_i               : destination register
//   RSaddr_i/RTaddr_i        : read port addresses
//   RSdata_o/RTdata_o        : read port data (combinational, bypassed)
//   WBData_o                 : selected write-back value
//   WBCount_o                : number of committed write-backs (wraps)
module wb_register_file
  import cpu_pkg::*;
#(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int NREG   = cpu_pkg::NREG,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [XLEN-1:0]   RDData_i,
  input  logic [XLEN-1:0]   ALUResult_i,
  input  logic [ADDR_W-1:0] WriteReg_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [XLEN-1:0]   RSdata_o,
  output logic [XLEN-1:0]   RTdata_o,
  output logic [XLEN-1:0]   WBData_o,
  output logic [CNT_W-1:0]  WBCount_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [XLEN-1:0]  r_regs [NREG];
  logic [CNT_W-1:0] r_wb_count;
  logic [XLEN-1:0]  w_wb_val;
  logic             w_commit;

  wb_mux #(
    .W (XLEN)
  ) u_wb_mux (
    .i_sel  (MemToReg_i),
    .i_alu  (ALUResult_i),
    .i_mem  (RDData_i),
    .o_data (w_wb_val)
  );

  // Reset blocks the commit, which also disables the read bypass.
  assign w_commit = RegWrite_i && (WriteReg_i != ZERO_ADDR) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_regs[WriteReg_i] <= w_wb_val;
      r_wb_count         <= r_wb_count + CNT_W'(1);
    end
  end

  // Write-through: a read of the register being committed sees the new value
  // in the same cycle, so ID never needs a separate WB->ID forward.
  always_comb begin
    RSdata_o = r_regs[RSaddr_i];
    if (RSaddr_i == ZERO_ADDR) begin
      RSdata_o = '0;
    end else if (w_commit && (RSaddr_i == WriteReg_i)) begin
      RSdata_o = w_wb_val;
    end
  end

  always_comb begin
    RTdata_o = r_regs[RTaddr_i];
    if (RTaddr_i == ZERO_ADDR) begin
      RTdata_o = '0;
    end else if (w_commit && (RTaddr_i == WriteReg_i)) begin
      RTdata_o = w_wb_val;
    end
  end

  assign WBData_o  = w_wb_val;
  assign WBCount_o = r_wb_count;

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

  logic        clk;
  logic        rst;
  logic        regwrite;
  logic        memtoreg;
  logic [31:0] rddata;
  logic [31:0] aluresult;
  logic [4:0]  writereg;
  logic [4:0]  rsaddr;
  logic [4:0]  rtaddr;
  logic [31:0] rsdata;
  logic [31:0] rtdata;
  logic [31:0] wbdata;
  logic [31:0] wbcount;

  // Second instance with a narrow counter so wrap-around is reachable.
  logic        c_rst;
  logic        c_regwrite;
  logic        c_memtoreg;
  logic [31:0] c_rddata;
  logic [31:0] c_aluresult;
  logic [4:0]  c_writereg;
  logic [4:0]  c_rsaddr;
  logic [4:0]  c_rtaddr;
  logic [31:0] c_rsdata;
  logic [31:0] c_rtdata;
  logic [31:0] c_wbdata;
  logic [3:0]  c_wbcount;

  int n_cmp;
  int n_fail;

  wb_register_file dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .RegWrite_i  (regwrite),
    .MemToReg_i  (memtoreg),
    .RDData_i    (rddata),
    .ALUResult_i (aluresult),
    .WriteReg_i  (writereg),
    .RSaddr_i    (rsaddr),
    .RTaddr_i    (rtaddr),
    .RSdata_o    (rsdata),
    .RTdata_o    (rtdata),
    .WBData_o    (wbdata),
    .WBCount_o   (wbcount)
  );

  wb_register_file #(
    .CNT_W (4)
  ) dut_cnt (
    .clk_i       (clk),
    .rst_i       (c_rst),
    .RegWrite_i  (c_regwrite),
    .MemToReg_i  (c_memtoreg),
    .RDData_i    (c_rddata),
    .ALUResult_i (c_aluresult),
    .WriteReg_i  (c_writereg),
    .RSaddr_i    (c_rsaddr),
    .RTaddr_i    (c_rtaddr),
    .RSdata_o    (c_rsdata),
    .RTdata_o    (c_rtdata),
    .WBData_o    (c_wbdata),
    .WBCount_o   (c_wbcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ALU-result commit on the main instance.
  task automatic alu_write(input logic [4:0] addr, input logic [31:0] val);
    regwrite  = 1'b1;
    memtoreg  = 1'b0;
    aluresult = val;
    writereg  = addr;
    step();
    regwrite  = 1'b0;
  endtask

  task automatic test_reset();
    alu_write(5'd1, 32'h0000_0011);
    alu_write(5'd2, 32'h0000_0022);
    alu_write(5'd3, 32'h0000_0033);
    rsaddr = 5'd2;
    rtaddr = 5'd3;
    #1;
    n_cmp++;
    if (rsdata !== 32'h0000_0022) begin
      n_fail++;
      $display("FAIL reset_preload_rs: got %h want %h", rsdata, 32'h0000_0022);
    end
    n_cmp++;
    if (wbcount !== 32'd3) begin
      n_fail++;
      $display("FAIL reset_preload_cnt: got %0d want 3", wbcount);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rsaddr = 5'(i);
      rtaddr = 5'(31 - i);
      #1;
      n_cmp++;
      if (rsdata !== 32'h0 || rtdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: rs=%h rt=%h want 0", i, rsdata, rtdata);
      end
    end
    n_cmp++;
    if (wbcount !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", wbcount);
    end
  endtask

  task automatic test_alu_write();
    alu_write(5'd5, 32'h1234_5678);
    rsaddr = 5'd5;
    #1;
    n_cmp++;
    if (rsdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_write_rs: got %h want %h", rsdata, 32'h1234_5678);
    end
    n_cmp++;
    if (wbcount !== 32'd1) begin
      n_fail++;
      $display("FAIL alu_write_cnt: got %0d want 1", wbcount);
    end
  endtask

  task automatic test_load_bypass();
    regwrite  = 1'b1;
    memtoreg  = 1'b1;
    rddata    = 32'hDEAD_BEEF;
    aluresult = 32'h1111_1111;
    writereg  = 5'd7;
    rsaddr    = 5'd7;
    rtaddr    = 5'd7;
    #1;
    n_cmp++;
    if (rsdata !== 32'hDEAD_BEEF || rtdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_bypass: rs=%h rt=%h want %h", rsdata, rtdata, 32'hDEAD_BEEF);
    end
    n_cmp++;
    if (wbdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_wbdata: got %h want %h", wbdata, 32'hDEAD_BEEF);
    end
    step();
    regwrite = 1'b0;
    memtoreg = 1'b0;
    #1;
    n_cmp++;
    if (rsdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_stored: got %h want %h", rsdata, 32'hDEAD_BEEF);
    end
    n_cmp++;
    if (wbdata !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL alu_select: got %h want %h", wbdata, 32'h1111_1111);
    end
    n_cmp++;
    if (wbcount !== 32'd2) begin
      n_fail++;
      $display("FAIL load_cnt: got %0d want 2", wbcount);
    end
  endtask

  task automatic test_zero_reg();
    regwrite  = 1'b1;
    memtoreg  = 1'b0;
    aluresult = 32'hFFFF_FFFF;
    writereg  = 5'd0;
    rsaddr    = 5'd0;
    rtaddr    = 5'd0;
    #1;
    n_cmp++;
    if (rsdata !== 32'h0 || rtdata !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_bypass: rs=%h rt=%h want 0", rsdata, rtdata);
    end
    step();
    regwrite = 1'b0;
    #1;
    n_cmp++;
    if (rsdata !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_stored: got %h want 0", rsdata);
    end
    n_cmp++;
    if (wbcount !== 32'd2) begin
      n_fail++;
      $display("FAIL zero_cnt: got %0d want 2", wbcount);
    end
  endtask

  task automatic test_reset_mid_write();
    alu_write(5'd3, 32'h0000_0033);
    rst       = 1'b1;
    regwrite  = 1'b1;
    memtoreg  = 1'b0;
    aluresult = 32'hA5A5_A5A5;
    writereg  = 5'd3;
    rsaddr    = 5'd3;
    #1;
    n_cmp++;
    if (rsdata !== 32'h0000_0033) begin
      n_fail++;
      $display("FAIL rst_no_bypass: got %h want %h", rsdata, 32'h0000_0033);
    end
    step();
    rst      = 1'b0;
    regwrite = 1'b0;
    #1;
    n_cmp++;
    if (rsdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_reg3: got %h want 0", rsdata);
    end
    n_cmp++;
    if (wbcount !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_cnt: got %0d want 0", wbcount);
    end
  endtask

  task automatic test_idle();
    alu_write(5'd9, 32'h0000_0099);
    regwrite  = 1'b0;
    aluresult = 32'h7777_7777;
    writereg  = 5'd9;
    rsaddr    = 5'd9;
    rtaddr    = 5'd5;
    #1;
    n_cmp++;
    if (rsdata !== 32'h0000_0099) begin
      n_fail++;
      $display("FAIL idle_no_bypass: got %h want %h", rsdata, 32'h0000_0099);
    end
    step();
    #1;
    n_cmp++;
    if (rsdata !== 32'h0000_0099 || rtdata !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_regs: rs=%h rt=%h want 00000099/0", rsdata, rtdata);
    end
    n_cmp++;
    if (wbcount !== 32'd1) begin
      n_fail++;
      $display("FAIL idle_cnt: got %0d want 1", wbcount);
    end
  endtask

  task automatic test_counter_wrap();
    c_regwrite  = 1'b1;
    c_memtoreg  = 1'b0;
    c_writereg  = 5'd1;
    for (int i = 1; i <= 15; i++) begin
      c_aluresult = 32'(i);
      step();
    end
    c_regwrite = 1'b0;
    c_rsaddr   = 5'd1;
    #1;
    n_cmp++;
    if (c_wbcount !== 4'hF) begin
      n_fail++;
      $display("FAIL wrap_full: got %h want f", c_wbcount);
    end
    n_cmp++;
    if (c_rsdata !== 32'd15) begin
      n_fail++;
      $display("FAIL wrap_reg1: got %h want f", c_rsdata);
    end
    c_regwrite  = 1'b1;
    c_aluresult = 32'hCAFE_0001;
    step();
    c_regwrite = 1'b0;
    #1;
    n_cmp++;
    if (c_wbcount !== 4'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h want 0", c_wbcount);
    end
    n_cmp++;
    if (c_rsdata !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL wrap_data: got %h want %h", c_rsdata, 32'hCAFE_0001);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    rddata      = '0;
    aluresult   = '0;
    writereg    = '0;
    rsaddr      = '0;
    rtaddr      = '0;
    c_rst       = 1'b1;
    c_regwrite  = 1'b0;
    c_memtoreg  = 1'b0;
    c_rddata    = '0;
    c_aluresult = '0;
    c_writereg  = '0;
    c_rsaddr    = '0;
    c_rtaddr    = '0;
    step();
    step();
    rst   = 1'b0;
    c_rst = 1'b0;
    n_cmp++;
    if (wbcount !== 32'd0 || rsdata !== 32'h0) begin
      n_fail++;
      $display("FAIL init_reset: cnt=%0d rs=%h want 0/0", wbcount, rsdata);
    end
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_zero_reg();
    test_reset_mid_write();
    test_idle();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
